// File: rtl/core_types_pkg.sv
// Shared core sizes plus the revert controller's FSM state type.
package core_types_pkg;

    localparam int unsigned ROB_ENTRIES = 64;

    typedef logic [5:0] ROB_index_t;
    typedef logic [4:0] arch_reg_tag_t;
    typedef logic [6:0] phys_reg_tag_t;
    typedef logic [2:0] checkpoint_column_t;

    typedef enum logic [1:0] {
        IDLE,
        RESTORE,
        WALK,
        DONE
    } revert_ctrl_state_t;

endpackage

// File: rtl/phys_reg_revert_controller.sv
// Map-table recovery initiator: checkpoint restore first, else ROB back-walk with reverts.
// Optional saturating statistics counters under PHYS_REG_REVERT_STATS_EN.
module phys_reg_revert_controller
    import core_types_pkg::*;
#(
    parameter bit SKIP_ARCH_REG_ZERO = 1'b1
) (
    input  logic               CLK,
    input  logic               nRST,
    output logic               DUT_error,
    input  logic               mispredict_valid,
    output logic               mispredict_ready,
    input  ROB_index_t         mispredict_ROB_index,
    input  logic               mispredict_checkpoint_valid,
    input  checkpoint_column_t mispredict_checkpoint_column,
    input  ROB_index_t         ROB_tail_index,
    output logic               restore_checkpoint_valid,
    output logic               restore_checkpoint_speculate_failed,
    output ROB_index_t         restore_checkpoint_ROB_index,
    output checkpoint_column_t restore_checkpoint_safe_column,
    input  logic               restore_checkpoint_success,
    output logic               revert_valid,
    output arch_reg_tag_t      revert_dest_arch_reg_tag,
    output phys_reg_tag_t      revert_safe_dest_phys_reg_tag,
    output phys_reg_tag_t      revert_speculated_dest_phys_reg_tag,
    output ROB_index_t         ROB_read_index,
    input  logic               ROB_read_writes_reg,
    input  arch_reg_tag_t      ROB_read_dest_arch_reg_tag,
    input  phys_reg_tag_t      ROB_read_safe_dest_phys_reg_tag,
    input  phys_reg_tag_t      ROB_read_speculated_dest_phys_reg_tag,
    output logic               busy,
    output logic               revert_done
`ifdef PHYS_REG_REVERT_STATS_EN
    ,
    output logic [15:0]        stat_restore_hits,
    output logic [15:0]        stat_restore_misses,
    output logic [15:0]        stat_reverts_issued
`endif
);

    revert_ctrl_state_t state;
    ROB_index_t         walk_index;
    ROB_index_t         mp_index;
    ROB_index_t         tail_m1;
    checkpoint_column_t mp_column;
    logic               mp_cp_valid;

    logic walk_stop;
    logic restore_on;
    logic revert_fire;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            walk_index  <= '0;
            mp_index    <= '0;
            tail_m1     <= '0;
            mp_column   <= '0;
            mp_cp_valid <= 1'b0;
            DUT_error   <= 1'b0;
        end else begin
            // A request outside IDLE is a protocol violation and is otherwise ignored.
            if (mispredict_valid && state != IDLE) begin
                DUT_error <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (mispredict_valid) begin
                        mp_index    <= mispredict_ROB_index;
                        mp_column   <= mispredict_checkpoint_column;
                        mp_cp_valid <= mispredict_checkpoint_valid;
                        tail_m1     <= ROB_tail_index - ROB_index_t'(1);
                        if (mispredict_checkpoint_valid) begin
                            state <= RESTORE;
                        end else begin
                            walk_index <= ROB_tail_index - ROB_index_t'(1);
                            state      <= WALK;
                        end
                    end
                end
                RESTORE: begin
                    if (restore_checkpoint_success) begin
                        state <= DONE;
                    end else begin
                        walk_index <= tail_m1;
                        state      <= WALK;
                    end
                end
                WALK: begin
                    if (walk_stop) begin
                        state <= DONE;
                    end else begin
                        walk_index <= walk_index - ROB_index_t'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign walk_stop   = (walk_index == mp_index);
    assign restore_on  = (state == RESTORE) && mp_cp_valid;
    assign revert_fire = (state == WALK) && !walk_stop && ROB_read_writes_reg &&
                         !(SKIP_ARCH_REG_ZERO && (ROB_read_dest_arch_reg_tag == '0));

    assign mispredict_ready = (state == IDLE);
    assign busy             = (state != IDLE);
    assign revert_done      = (state == DONE);
    assign ROB_read_index   = walk_index;

    // The restore path only ever signals a failed speculation; clears belong to commit.
    assign restore_checkpoint_valid            = restore_on;
    assign restore_checkpoint_speculate_failed = restore_on;
    assign restore_checkpoint_ROB_index        = restore_on ? mp_index  : '0;
    assign restore_checkpoint_safe_column      = restore_on ? mp_column : '0;

    assign revert_valid                        = revert_fire;
    assign revert_dest_arch_reg_tag            = revert_fire ? ROB_read_dest_arch_reg_tag : '0;
    assign revert_safe_dest_phys_reg_tag       = revert_fire ? ROB_read_safe_dest_phys_reg_tag : '0;
    assign revert_speculated_dest_phys_reg_tag = revert_fire ? ROB_read_speculated_dest_phys_reg_tag : '0;

`ifdef PHYS_REG_REVERT_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_restore_hits   <= '0;
            stat_restore_misses <= '0;
            stat_reverts_issued <= '0;
        end else begin
            if (restore_on && restore_checkpoint_success && stat_restore_hits != '1) begin
                stat_restore_hits <= stat_restore_hits + 16'd1;
            end
            if (restore_on && !restore_checkpoint_success && stat_restore_misses != '1) begin
                stat_restore_misses <= stat_restore_misses + 16'd1;
            end
            if (revert_fire && stat_reverts_issued != '1) begin
                stat_reverts_issued <= stat_reverts_issued + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_phys_reg_revert_controller.sv
// Scoreboard bench: the issuer predicts restore/revert/done events per cycle, a negedge monitor checks them.
module tb_phys_reg_revert_controller;

    localparam int EV_RESTORE = 1;
    localparam int EV_REVERT  = 2;
    localparam int EV_DONE    = 3;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       DUT_error;
    logic       mispredict_valid;
    logic       mispredict_ready;
    logic [5:0] mispredict_ROB_index;
    logic       mispredict_checkpoint_valid;
    logic [2:0] mispredict_checkpoint_column;
    logic [5:0] ROB_tail_index;
    logic       restore_checkpoint_valid;
    logic       restore_checkpoint_speculate_failed;
    logic [5:0] restore_checkpoint_ROB_index;
    logic [2:0] restore_checkpoint_safe_column;
    logic       restore_checkpoint_success;
    logic       revert_valid;
    logic [4:0] revert_dest_arch_reg_tag;
    logic [6:0] revert_safe_dest_phys_reg_tag;
    logic [6:0] revert_speculated_dest_phys_reg_tag;
    logic [5:0] ROB_read_index;
    logic       ROB_read_writes_reg;
    logic [4:0] ROB_read_dest_arch_reg_tag;
    logic [6:0] ROB_read_safe_dest_phys_reg_tag;
    logic [6:0] ROB_read_speculated_dest_phys_reg_tag;
    logic       busy;
    logic       revert_done;
`ifdef PHYS_REG_REVERT_STATS_EN
    logic [15:0] stat_restore_hits;
    logic [15:0] stat_restore_misses;
    logic [15:0] stat_reverts_issued;
`endif

    always #5 CLK = ~CLK;

    phys_reg_revert_controller #(.SKIP_ARCH_REG_ZERO(1'b1)) dut (
        .CLK                                  (CLK),
        .nRST                                 (nRST),
        .DUT_error                            (DUT_error),
        .mispredict_valid                     (mispredict_valid),
        .mispredict_ready                     (mispredict_ready),
        .mispredict_ROB_index                 (mispredict_ROB_index),
        .mispredict_checkpoint_valid          (mispredict_checkpoint_valid),
        .mispredict_checkpoint_column         (mispredict_checkpoint_column),
        .ROB_tail_index                       (ROB_tail_index),
        .restore_checkpoint_valid             (restore_checkpoint_valid),
        .restore_checkpoint_speculate_failed  (restore_checkpoint_speculate_failed),
        .restore_checkpoint_ROB_index         (restore_checkpoint_ROB_index),
        .restore_checkpoint_safe_column       (restore_checkpoint_safe_column),
        .restore_checkpoint_success           (restore_checkpoint_success),
        .revert_valid                         (revert_valid),
        .revert_dest_arch_reg_tag             (revert_dest_arch_reg_tag),
        .revert_safe_dest_phys_reg_tag        (revert_safe_dest_phys_reg_tag),
        .revert_speculated_dest_phys_reg_tag  (revert_speculated_dest_phys_reg_tag),
        .ROB_read_index                       (ROB_read_index),
        .ROB_read_writes_reg                  (ROB_read_writes_reg),
        .ROB_read_dest_arch_reg_tag           (ROB_read_dest_arch_reg_tag),
        .ROB_read_safe_dest_phys_reg_tag      (ROB_read_safe_dest_phys_reg_tag),
        .ROB_read_speculated_dest_phys_reg_tag(ROB_read_speculated_dest_phys_reg_tag),
        .busy                                 (busy),
        .revert_done                          (revert_done)
`ifdef PHYS_REG_REVERT_STATS_EN
        ,
        .stat_restore_hits                    (stat_restore_hits),
        .stat_restore_misses                  (stat_restore_misses),
        .stat_reverts_issued                  (stat_reverts_issued)
`endif
    );

    // ROB contents and map-table response model
    logic       rob_wr  [64];
    logic [4:0] rob_arch[64];
    logic [6:0] rob_safe[64];
    logic [6:0] rob_spec[64];
    logic       succ_r;

    assign ROB_read_writes_reg                   = rob_wr[ROB_read_index];
    assign ROB_read_dest_arch_reg_tag            = rob_arch[ROB_read_index];
    assign ROB_read_safe_dest_phys_reg_tag       = rob_safe[ROB_read_index];
    assign ROB_read_speculated_dest_phys_reg_tag = rob_spec[ROB_read_index];
    assign restore_checkpoint_success            = succ_r;

    typedef struct {
        int         kind;
        int         cyc;
        logic [5:0] idx;
        logic [2:0] col;
        logic [4:0] arch;
        logic [6:0] safe;
        logic [6:0] spec;
    } ev_t;

    ev_t sbq[$];
    int  vectors    = 0;
    int  miscompares = 0;
    int  cyc        = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic pop_check(input int kind);
        ev_t e;
        if (sbq.size() == 0) begin
            chk("unexpected_output_kind", kind, 0);
            return;
        end
        e = sbq.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.cyc);
        if (kind == EV_RESTORE && e.kind == EV_RESTORE) begin
            chk("restore_rob_index", restore_checkpoint_ROB_index, e.idx);
            chk("restore_column", restore_checkpoint_safe_column, e.col);
            chk("restore_spec_failed", restore_checkpoint_speculate_failed, 1);
        end
        if (kind == EV_REVERT && e.kind == EV_REVERT) begin
            chk("revert_arch", revert_dest_arch_reg_tag, e.arch);
            chk("revert_safe", revert_safe_dest_phys_reg_tag, e.safe);
            chk("revert_spec", revert_speculated_dest_phys_reg_tag, e.spec);
        end
    endtask

    // Monitor: every presented output must match the front of the expected queue.
    always @(negedge CLK) begin
        if (nRST) begin
            if (restore_checkpoint_valid && revert_valid) chk("restore_revert_exclusive", 1, 0);
            if (restore_checkpoint_valid) pop_check(EV_RESTORE);
            if (revert_valid) pop_check(EV_REVERT);
            if (revert_done) pop_check(EV_DONE);
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                ev_t e;
                e = sbq.pop_front();
                chk("missing_event_kind", 0, e.kind);
            end
        end
    end

    function automatic ev_t mk(input int kind, input int cy);
        ev_t e;
        e.kind = kind; e.cyc = cy; e.idx = '0; e.col = '0;
        e.arch = '0; e.safe = '0; e.spec = '0;
        return e;
    endfunction

    // Called at a negedge while the DUT is idle; predicts the whole recovery sequence.
    task automatic issue_mp(input int idx, input bit cp, input int col, input int tail, input bit succ);
        int  c, n, ws;
        ev_t e;
        c = cyc;
        mispredict_valid             = 1'b1;
        mispredict_ROB_index         = 6'(idx);
        mispredict_checkpoint_valid  = cp;
        mispredict_checkpoint_column = 3'(col);
        ROB_tail_index               = 6'(tail);
        succ_r                       = succ;
        n = (((tail - 1 - idx) % 64) + 64) % 64;
        if (cp) begin
            e = mk(EV_RESTORE, c + 1);
            e.idx = 6'(idx); e.col = 3'(col);
            sbq.push_back(e);
        end
        if (cp && succ) begin
            sbq.push_back(mk(EV_DONE, c + 2));
        end else begin
            ws = cp ? c + 2 : c + 1;
            for (int k = 0; k < n; k++) begin
                int j;
                j = (((tail - 1 - k) % 64) + 64) % 64;
                if (rob_wr[j] && rob_arch[j] != 0) begin
                    e = mk(EV_REVERT, ws + k);
                    e.arch = rob_arch[j]; e.safe = rob_safe[j]; e.spec = rob_spec[j];
                    sbq.push_back(e);
                end
            end
            sbq.push_back(mk(EV_DONE, ws + n + 1));
        end
        @(negedge CLK);
        mispredict_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 300; t++) begin
            @(negedge CLK);
            if (sbq.size() == 0 && mispredict_ready) return;
        end
        chk("idle_timeout", 0, 1);
        sbq.delete();
    endtask

    task automatic rand_rob();
        for (int i = 0; i < 64; i++) begin
            rob_wr[i]   = ($urandom_range(0, 3) != 0);
            rob_arch[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            rob_safe[i] = 7'($urandom);
            rob_spec[i] = 7'($urandom);
        end
    endtask

    task automatic set_ent(input int i, input bit w, input int a);
        rob_wr[i] = w; rob_arch[i] = 5'(a);
        rob_safe[i] = 7'($urandom); rob_spec[i] = 7'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST = 1'b0;
        mispredict_valid = 1'b0;
        mispredict_ROB_index = '0;
        mispredict_checkpoint_valid = 1'b0;
        mispredict_checkpoint_column = '0;
        ROB_tail_index = '0;
        succ_r = 1'b0;
        rand_rob();
        repeat (3) @(negedge CLK);
        chk("reset_ready", mispredict_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_error", DUT_error, 0);
        chk("reset_restore_valid", restore_checkpoint_valid, 0);
        chk("reset_revert_valid", revert_valid, 0);
        chk("reset_done", revert_done, 0);
        chk("reset_read_index", ROB_read_index, 0);
        nRST = 1'b1;
        @(negedge CLK);

        // restore hit
        issue_mp(5, 1'b1, 2, 9, 1'b1);
        wait_idle();
        // restore miss, three writers
        set_ent(8, 1, 3); set_ent(7, 1, 9); set_ent(6, 1, 17);
        issue_mp(5, 1'b1, 2, 9, 1'b0);
        wait_idle();
        // non-writer and arch-zero entries skipped
        set_ent(7, 0, 4); set_ent(6, 1, 0);
        issue_mp(5, 1'b1, 2, 9, 1'b0);
        wait_idle();
        // wrap across index 0
        set_ent(0, 1, 5); set_ent(63, 1, 6);
        issue_mp(62, 1'b0, 0, 1, 1'b0);
        wait_idle();
        // empty walk
        issue_mp(10, 1'b0, 0, 11, 1'b0);
        chk("empty_walk_busy_c1", busy, 1);
        @(negedge CLK);
        chk("empty_walk_busy_c2", busy, 1);
        @(negedge CLK);
        chk("empty_walk_busy_c3", busy, 0);
        wait_idle();

        // protocol violation mid-walk is ignored but flagged
        rand_rob();
        issue_mp(0, 1'b0, 0, 40, 1'b0);
        repeat (3) @(negedge CLK);
        mispredict_valid = 1'b1;
        mispredict_ROB_index = 6'd20;
        mispredict_checkpoint_valid = 1'b1;
        @(negedge CLK);
        mispredict_valid = 1'b0;
        chk("protocol_error_set", DUT_error, 1);
        wait_idle();
        chk("protocol_error_sticky", DUT_error, 1);

        // reset in the middle of a walk
        issue_mp(3, 1'b0, 0, 50, 1'b0);
        repeat (4) @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        chk("midwalk_reset_busy", busy, 0);
        chk("midwalk_reset_ready", mispredict_ready, 1);
        chk("midwalk_reset_revert", revert_valid, 0);
        chk("midwalk_reset_error", DUT_error, 0);
        sbq.delete();
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        for (int t = 0; t < 40; t++) begin
            int idx, tail;
            rand_rob();
            idx  = $urandom_range(0, 63);
            tail = (idx + 1 + (($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 12))) % 64;
            issue_mp(idx, 1'($urandom_range(0, 1)), $urandom_range(0, 7), tail, 1'($urandom_range(0, 1)));
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/phys_reg_revert_controller.md
Name: phys_reg_revert_controller

Overview:
Initiator side of the phys_reg_map_table restore/revert interface. It sits in dispatch_unit beside the map table.
- On a branch mispredict, it first attempts a one-cycle checkpoint restore.
- If the restore fails (column overwritten or invalid), it walks the ROB backwards from tail-1 toward the mispredicting instruction. For each entry that wrote a register, it issues one revert per cycle.
- It stalls dispatch (busy) until the map table is consistent.

Parameters:
SKIP_ARCH_REG_ZERO, 1, when 1 no revert is issued for dest arch reg 0.
(Sizes come from core_types_pkg: ROB_index_t, arch_reg_tag_t, phys_reg_tag_t, checkpoint_column_t.)

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
DUT_error  out  1  registered protocol-violation flag
mispredict_valid  in  1  mispredict request
mispredict_ready  out  1  =1 only in IDLE
mispredict_ROB_index  in  ROB_index_t  mispredicting instr (kept, not reverted)
mispredict_checkpoint_valid  in  1  instr saved a checkpoint
mispredict_checkpoint_column  in  checkpoint_column_t  column from save_checkpoint_safe_column
ROB_tail_index  in  ROB_index_t  next free ROB slot
restore_checkpoint_valid  out  1  to map table
restore_checkpoint_speculate_failed  out  1  to map table
restore_checkpoint_ROB_index  out  ROB_index_t  to map table
restore_checkpoint_safe_column  out  checkpoint_column_t  to map table
restore_checkpoint_success  in  1  from map table (comb, same cycle)
revert_valid  out  1  to map table
revert_dest_arch_reg_tag  out  arch_reg_tag_t
revert_safe_dest_phys_reg_tag  out  phys_reg_tag_t
revert_speculated_dest_phys_reg_tag  out  phys_reg_tag_t
ROB_read_index  out  ROB_index_t  async ROB read address
ROB_read_writes_reg  in  1  entry has dest
ROB_read_dest_arch_reg_tag  in  arch_reg_tag_t
ROB_read_safe_dest_phys_reg_tag  in  phys_reg_tag_t
ROB_read_speculated_dest_phys_reg_tag  in  phys_reg_tag_t
busy  out  1  =1 in any state except IDLE; dispatch stall
revert_done  out  1  one-cycle pulse in DONE

Behaviour:
- Reset: state=IDLE; walk_index=0; all captured regs=0; all outputs 0 except mispredict_ready=1.
- States are IDLE, RESTORE, WALK, DONE.
- IDLE:
  - On mispredict_valid, latch index, column, checkpoint_valid and tail_index-1.
  - If checkpoint_valid, go to RESTORE; else go to WALK with walk_index=tail-1.
- RESTORE (1 cycle):
  - Drive restore_checkpoint_valid=1 and speculate_failed=1, with the latched ROB index and column.
  - If restore_checkpoint_success, go to DONE.
  - Else go to WALK with walk_index=latched tail-1.
- WALK:
  - ROB_read_index=walk_index (combinational).
  - If walk_index==mispredict index, go to DONE with no revert that cycle.
  - Else, if ROB_read_writes_reg and not (SKIP_ARCH_REG_ZERO and arch tag==0), drive revert_valid=1 with the read fields passed straight through.
  - Then walk_index-=1, wrapping mod 2^width(ROB_index_t).
- DONE: revert_done=1 for one cycle, then go to IDLE.
- Latency:
  - Restore hit: mispredict to revert_done = 2 cycles after accept.
  - Restore miss: 1 restore cycle + N walk cycles + 1 compare cycle + 1 DONE cycle, where N = (tail-1-mispredict) mod ROB size.
- Boundaries:
  - Empty walk (tail-1==mispredict index): WALK to DONE in 1 cycle, zero reverts.
  - Wrap from index 0 to max is mandatory.
- Simultaneous events:
  - restore_checkpoint_valid and revert_valid are never high in the same cycle.
  - The outputs never drive speculate_failed=0; checkpoint-invalidate traffic is owned by the commit path.
- Protocol error: mispredict_valid while mispredict_ready=0 sets DUT_error next cycle; the request is ignored. DUT_error stays set until reset.
- Reset mid-walk: immediate return to IDLE; the partial walk is abandoned.

Optional Feature:
PHYS_REG_REVERT_STATS_EN:
- Defined: adds outputs stat_restore_hits (16b), stat_restore_misses (16b) and stat_reverts_issued (16b).
  - Counters are saturating and reset to 0.
  - They increment on RESTORE success, on RESTORE fail, and on each revert_valid cycle respectively.
- Undefined: no counters and no ports.

Decomposition:
- core_types_pkg gains revert_ctrl_state_t (enum IDLE, RESTORE, WALK, DONE).
- Existing ROB_index_t, arch_reg_tag_t, phys_reg_tag_t and checkpoint_column_t are reused.
- No sub-module; single FSM plus walk counter.

Test Plan:
1. Restore hit: checkpoint_valid=1, column=2, ROB idx=5, success=1 in RESTORE -> restore outputs high for 1 cycle; no revert_valid; revert_done 2 cycles after accept.
2. Restore miss, walk: idx=5, tail=9, success=0 -> ROB_read_index 8,7,6, then 5 stops; 3 reverts issued with the read tags; revert_done follows.
3. Walk skipping: among 8,7,6, entry 7 has writes_reg=0 and entry 6 has arch reg 0 -> only entry 8 reverts; cycle count unchanged.
4. Wrap: idx=62, tail=1 (64-entry ROB), no checkpoint -> reads 0,63, then 62 stops; 2 reverts.
5. Empty walk: idx=10, tail=11, no checkpoint -> zero reverts; busy lasts 2 cycles.
6. Protocol error: mispredict_valid in WALK -> DUT_error=1 next cycle; walk continues unchanged. nRST low mid-walk -> IDLE, busy=0 immediately.
